// File: rtl/boot_selector_if.sv
// Button-in / warm-boot-out bundle between the glitch filter, the selector and SB_WARMBOOT.
// The selector uses the slave view; whoever drives the button uses master.
interface boot_selector_if #(
  parameter int SEL_W = 2
);
  logic             btn_pressed;
  logic             boot;
  logic [SEL_W-1:0] boot_sel;
  logic             selecting;
  logic             holding;

  modport master (output btn_pressed, input boot, boot_sel, selecting, holding);
  modport slave  (input btn_pressed, output boot, boot_sel, selecting, holding);
endinterface

// File: rtl/boot_selector.sv
// Warm-boot image selector: short press advances the offered image, long press or idle timeout boots it.
// All outputs are registered and follow the state register by one cycle.
module boot_selector #(
  parameter int N_IMAGES    = 4,
  parameter int SEL_W       = 2,
  parameter int DEF_IMAGE   = 2,
  parameter int SEL_INIT    = 1,
  parameter int TIMER_W     = 24,
  parameter int TIMEOUT_CYC = 8388608,
  parameter int REARM_CYC   = 32768,
  parameter int LONG_CYC    = 6000000,
  parameter int LONG_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  boot_selector_if.slave        bus
);

  typedef enum logic [2:0] {
    ST_START,
    ST_WAIT,
    ST_SEL,
    ST_HOLD,
    ST_REARM,
    ST_BOOT
  } state_t;

  localparam logic [SEL_W-1:0]   DEF_SEL     = SEL_W'(DEF_IMAGE);
  localparam logic [SEL_W-1:0]   INIT_SEL    = SEL_W'(SEL_INIT);
  localparam logic [SEL_W-1:0]   LAST_SEL    = SEL_W'(N_IMAGES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_END = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] REARM_END   = TIMER_W'(REARM_CYC - 1);
  localparam logic [TIMER_W-1:0] LONG_END    = TIMER_W'(LONG_CYC - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               btn_prev_q, btn_prev_d;
  logic               boot_q, boot_d;
  logic [SEL_W-1:0]   boot_sel_q, boot_sel_d;
  logic               selecting_q, selecting_d;
  logic               holding_q, holding_d;
  logic               press_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_START;
      timer_q     <= '0;
      btn_prev_q  <= 1'b0;
      boot_q      <= 1'b0;
      boot_sel_q  <= DEF_SEL;
      selecting_q <= 1'b0;
      holding_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      btn_prev_q  <= btn_prev_d;
      boot_q      <= boot_d;
      boot_sel_q  <= boot_sel_d;
      selecting_q <= selecting_d;
      holding_q   <= holding_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_sel_d  = boot_sel_q;
    btn_prev_d  = bus.btn_pressed;
    press_r     = bus.btn_pressed & ~btn_prev_q;

    case (state_q)
      ST_START: begin
        if (bus.btn_pressed) begin
          state_d    = ST_WAIT;
          boot_sel_d = INIT_SEL;
        end else begin
          state_d = ST_BOOT;
        end
      end
      ST_WAIT: begin
        if (!bus.btn_pressed) state_d = ST_SEL;
      end
      ST_SEL: begin
        // A fresh press beats the idle timeout landing on the same cycle.
        if (press_r)                     state_d = ST_HOLD;
        else if (timer_q == TIMEOUT_END) state_d = ST_BOOT;
      end
      ST_HOLD: begin
        // Release is checked first so a release on the threshold cycle is still a short press.
        if (!bus.btn_pressed) begin
          state_d    = ST_REARM;
          boot_sel_d = (boot_sel_q == LAST_SEL) ? '0 : boot_sel_q + SEL_W'(1);
        end else if ((LONG_EN != 0) && (timer_q == LONG_END)) begin
          state_d = ST_BOOT;
        end
      end
      ST_REARM: begin
        if (timer_q == REARM_END) state_d = ST_SEL;
      end
      ST_BOOT: begin
        state_d = ST_BOOT;
      end
      default: begin
        state_d = ST_START;
      end
    endcase

    // Timer restarts on every transition and saturates instead of wrapping.
    if (state_d != state_q) timer_d = '0;
    else if (&timer_q)      timer_d = timer_q;
    else                    timer_d = timer_q + TIMER_W'(1);

    boot_d      = (state_q == ST_BOOT);
    selecting_d = (state_q == ST_WAIT) || (state_q == ST_SEL) ||
                  (state_q == ST_HOLD) || (state_q == ST_REARM);
    holding_d   = (state_q == ST_HOLD);
  end

  assign bus.boot      = boot_q;
  assign bus.boot_sel  = boot_sel_q;
  assign bus.selecting = selecting_q;
  assign bus.holding   = holding_q;

endmodule

// File: tb/tb_boot_selector.sv
// Directed bench for boot_selector with N_IMAGES=3, DEF_IMAGE=2, SEL_INIT=1, short timeouts.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_boot_selector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  boot_selector_if #(.SEL_W(2)) bus();

  boot_selector #(
    .N_IMAGES   (3),
    .SEL_W      (2),
    .DEF_IMAGE  (2),
    .SEL_INIT   (1),
    .TIMER_W    (8),
    .TIMEOUT_CYC(100),
    .REARM_CYC  (10),
    .LONG_CYC   (50),
    .LONG_EN    (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Holds reset for two cycles, checks reset outputs, releases it on a falling edge.
  task automatic do_reset(input logic btn);
    @(negedge clk);
    rst = 1'b1;
    bus.btn_pressed = btn;
    tick(2);
    check_eq("rst_boot", bus.boot, 1'b0);
    check_eq("rst_sel", bus.boot_sel, 2'd2);
    check_eq("rst_selecting", bus.selecting, 1'b0);
    check_eq("rst_holding", bus.holding, 1'b0);
    rst = 1'b0;
  endtask

  // Start with the button held, release it; SEL is entered on the next rising edge.
  task automatic enter_sel();
    do_reset(1'b1);
    tick(1);
    check_eq("init_sel", bus.boot_sel, 2'd1);
    tick(1);
    check_eq("wait_selecting", bus.selecting, 1'b1);
    bus.btn_pressed = 1'b0;
  endtask

  task automatic short_press();
    tick(20);
    bus.btn_pressed = 1'b1;
    tick(5);
    bus.btn_pressed = 1'b0;
  endtask

  int exp_seq [3] = '{2, 0, 1};

  initial begin
    bus.btn_pressed = 1'b0;

    // Button released at start: straight to boot of the default image.
    do_reset(1'b0);
    tick(1);
    check_eq("idle_boot_early", bus.boot, 1'b0);
    tick(1);
    check_eq("idle_boot", bus.boot, 1'b1);
    check_eq("idle_sel", bus.boot_sel, 2'd2);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_eq("idle_selecting", bus.selecting, 1'b0);
      check_eq("idle_boot_hold", bus.boot, 1'b1);
    end
    $display("tx idle_start boot=%0d sel=%0d", bus.boot, bus.boot_sel);

    // Held at start, released, then idle until the select timeout.
    enter_sel();
    tick(101);
    check_eq("tmo_boot_early", bus.boot, 1'b0);
    check_eq("tmo_selecting", bus.selecting, 1'b1);
    tick(1);
    check_eq("tmo_boot", bus.boot, 1'b1);
    check_eq("tmo_sel", bus.boot_sel, 2'd1);
    check_eq("tmo_selecting_off", bus.selecting, 1'b0);
    $display("tx timeout boot=%0d sel=%0d", bus.boot, bus.boot_sel);

    // Three short presses walk 1 -> 2 -> 0 -> 1, then auto-boot.
    enter_sel();
    for (int i = 0; i < 3; i++) begin
      short_press();
      tick(1);
      check_eq("adv_sel", bus.boot_sel, 32'(exp_seq[i]));
      check_eq("adv_selecting", bus.selecting, 1'b1);
      $display("tx short_press %0d sel=%0d", i, bus.boot_sel);
    end
    tick(110);
    check_eq("adv_boot_early", bus.boot, 1'b0);
    tick(1);
    check_eq("adv_boot", bus.boot, 1'b1);
    check_eq("adv_final_sel", bus.boot_sel, 2'd1);

    // Long hold confirms the current image at hold cycle 50.
    enter_sel();
    tick(20);
    bus.btn_pressed = 1'b1;
    tick(2);
    check_eq("long_holding", bus.holding, 1'b1);
    tick(49);
    check_eq("long_boot_early", bus.boot, 1'b0);
    check_eq("long_holding_late", bus.holding, 1'b1);
    tick(1);
    check_eq("long_boot", bus.boot, 1'b1);
    check_eq("long_holding_off", bus.holding, 1'b0);
    check_eq("long_sel", bus.boot_sel, 2'd1);
    tick(8);
    bus.btn_pressed = 1'b0;
    tick(5);
    check_eq("long_after_rel_boot", bus.boot, 1'b1);
    check_eq("long_after_rel_sel", bus.boot_sel, 2'd1);
    $display("tx long_press boot=%0d sel=%0d", bus.boot, bus.boot_sel);

    // Release on the long-press threshold cycle counts as a short press.
    enter_sel();
    tick(20);
    bus.btn_pressed = 1'b1;
    tick(50);
    bus.btn_pressed = 1'b0;
    tick(1);
    check_eq("edge_sel", bus.boot_sel, 2'd2);
    check_eq("edge_boot", bus.boot, 1'b0);
    // Press during rearm lockout is ignored.
    tick(4);
    bus.btn_pressed = 1'b1;
    tick(3);
    bus.btn_pressed = 1'b0;
    tick(5);
    check_eq("lock_sel", bus.boot_sel, 2'd2);
    check_eq("lock_holding", bus.holding, 1'b0);
    check_eq("lock_boot", bus.boot, 1'b0);
    check_eq("lock_selecting", bus.selecting, 1'b1);
    $display("tx threshold_release sel=%0d", bus.boot_sel);

    // Reset in REARM discards the selection.
    short_press();
    tick(1);
    check_eq("pre_rst_sel", bus.boot_sel, 2'd0);
    tick(3);
    check_eq("pre_rst_selecting", bus.selecting, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_sel", bus.boot_sel, 2'd2);
    check_eq("mid_rst_boot", bus.boot, 1'b0);
    check_eq("mid_rst_selecting", bus.selecting, 1'b0);
    check_eq("mid_rst_holding", bus.holding, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(1);
    check_eq("restart_boot_early", bus.boot, 1'b0);
    tick(1);
    check_eq("restart_boot", bus.boot, 1'b1);
    check_eq("restart_sel", bus.boot_sel, 2'd2);
    $display("tx mid_reset boot=%0d sel=%0d", bus.boot, bus.boot_sel);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_selector.md
Name: boot_selector

Overview:
- Parametrised warm-boot image selector for iCE40 stub bitstreams; sits between the button glitch filter and SB_WARMBOOT.
- Generalises the fixed 4-image, 2-timer selector:
  - configurable image count with wrap at N_IMAGES.
  - cycle-exact configurable timeouts.
  - short-press-to-advance / long-press-to-confirm.
  - a status output for LED drivers.
- Selection is applied on button release, not on press.

Parameters:
- N_IMAGES, 4: number of selectable images, 2..2^SEL_W.
- SEL_W, 2: width of boot_sel (2 for SB_WARMBOOT S1:S0).
- DEF_IMAGE, 2: image booted when button not held at start; also boot_sel reset value.
- SEL_INIT, 1: first image offered when entering select mode (DFU).
- TIMER_W, 24: internal timer width; every *_CYC parameter < 2^TIMER_W.
- TIMEOUT_CYC, 8388608: idle cycles in select mode before auto-boot.
- REARM_CYC, 32768: lockout cycles after a short press.
- LONG_CYC, 6000000: hold cycles that confirm the current selection immediately.
- LONG_EN, 1: 0 disables long-press confirm; holds then only end on release.

Ports:
- clk, in, 1: system clock (12 MHz HFOSC).
- rst, in, 1: asynchronous active-high reset.
- btn_pressed, in, 1: debounced, clk-synchronous button level; 1 = pressed.
- boot, out, 1: registered; high = assert SB_WARMBOOT BOOT.
- boot_sel, out, SEL_W: registered image index to S[SEL_W-1:0].
- selecting, out, 1: registered; high in WAIT/SEL/HOLD/REARM.
- holding, out, 1: registered; high in HOLD (LED feedback).

Behaviour:
- Reset values (async on rst):
  - state = START; timer = 0; btn_prev = 0.
  - boot = 0; boot_sel = DEF_IMAGE; selecting = 0; holding = 0.
- Press edge is press_r = btn_pressed & ~btn_prev; btn_prev updates every cycle.
- Timer:
  - Clears to 0 on every state transition.
  - Otherwise increments by 1 per cycle, saturating at all-ones; it never wraps.
  - Threshold tests are timer == X_CYC-1, so each event fires exactly X_CYC cycles after state entry.
- START (exactly one cycle):
  - btn_pressed = 0: go to BOOT; boot_sel stays DEF_IMAGE.
  - btn_pressed = 1: go to WAIT; boot_sel <= SEL_INIT.
- WAIT: stay until btn_pressed = 0, then go to SEL. No timeout.
- SEL:
  - press_r = 1: go to HOLD.
  - Else timer == TIMEOUT_CYC-1: go to BOOT.
  - press_r wins over timeout in the same cycle.
- HOLD:
  - btn_pressed = 0: boot_sel advances by one, wrapping N_IMAGES-1 -> 0; go to REARM.
  - Else LONG_EN && timer == LONG_CYC-1: go to BOOT; boot_sel unchanged.
  - Release is tested first, so a release on the threshold cycle counts as a short press.
- REARM:
  - Presses are ignored.
  - timer == REARM_CYC-1: go to SEL.
  - A press still active on entry to SEL is not an edge; a new press is required.
- BOOT:
  - Terminal; boot = 1 from the cycle after entry, held until rst.
  - boot_sel frozen; selecting = 0; holding = 0.
- Output timing: all outputs are registered and track state with 1-cycle latency.
- boot_sel changes only in START->WAIT and HOLD->REARM, so it is stable for ≥1 cycle before boot rises.
- rst mid-operation returns to START with boot_sel = DEF_IMAGE; the selection is discarded.
- N_IMAGES = 2^SEL_W: wrap equals natural overflow.
- N_IMAGES < 2^SEL_W: values ≥ N_IMAGES are never produced.

Test Plan:
Bench parameters: N_IMAGES=3, DEF_IMAGE=2, SEL_INIT=1, TIMEOUT_CYC=100, REARM_CYC=10, LONG_CYC=50, TIMER_W=8.
- Button released at rst deassert -> boot=1 two cycles later; boot_sel=2; selecting never high.
- Button held at start, released, idle -> selecting=1; boot_sel=1; boot rises exactly 100 cycles after SEL entry (+1 register) with boot_sel=1.
- Held start; then short presses (5 cycles each, 20-cycle gaps) x3 -> boot_sel 1->2->0->1; auto-boot 100 cycles after last REARM exit; boot_sel=1.
- In SEL, hold button 60 cycles -> holding=1; boot at hold cycle 50 with boot_sel unchanged; the later release has no effect.
- Release exactly on hold cycle 50 -> treated as short press: boot_sel increments, no boot.
  - Second press inside REARM lockout (cycle 5) -> ignored, boot_sel unchanged.
- Assert rst while in REARM with boot_sel=0 -> immediately boot_sel=2, boot=0, selecting=0; the sequence restarts from START.
